// File: rtl/light_show_sequencer_if.sv
// Control and status bundle for the light show sequencer.
// master drives start/stop/mode; slave returns the LED image and sequencer status.
interface light_show_sequencer_if #(
    parameter int N_LEDS = 10
);
    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic [N_LEDS-1:0] leds;
    logic [2:0]        state;
    logic [3:0]        repCount;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, mode,
        input  leds, state, repCount, busy, done
    );

    modport slave (
        input  start, stop, mode,
        output leds, state, repCount, busy, done
    );
endinterface

// File: rtl/light_show_sequencer.sv
// LED show sequencer: INTRO pass (slow), REPS SHOW passes (fast), OUTRO drain, then DONE.
// leds/state/repCount registered, one-edge response to start/stop; no backpressure, stop beats start.
module light_show_sequencer #(
    parameter int N_LEDS     = 10,
    parameter int SLOW_TICKS = 100000000,
    parameter int FAST_TICKS = 5000000,
    parameter int NORM_TICKS = 50000000,
    parameter int REPS       = 9
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 resetN,
    light_show_sequencer_if.slave bus
);
    localparam int MAX_AB = (SLOW_TICKS > FAST_TICKS) ? SLOW_TICKS : FAST_TICKS;
    localparam int MAX_T  = (MAX_AB > NORM_TICKS) ? MAX_AB : NORM_TICKS;
    localparam int TICK_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int STEP_W = $clog2(2 * N_LEDS - 1);

    localparam logic [N_LEDS-1:0] ONE        = N_LEDS'(1);
    localparam logic [STEP_W-1:0] LAST_LED   = STEP_W'(N_LEDS - 1);
    localparam logic [STEP_W-1:0] BOUNCE_TOP = STEP_W'(2 * N_LEDS - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INTRO = 3'd1,
        S_SHOW  = 3'd2,
        S_OUTRO = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d, t_last;
    logic [STEP_W-1:0]   step_q, step_d, s_last;
    logic [1:0]          mode_q, mode_d;
    logic [3:0]          rep_q, rep_d;
    logic [N_LEDS-1:0]   leds_q, leds_d;
    logic                tick_end, step_end;

    // LED image for a given phase/step; IDLE and DONE are dark.
    function automatic logic [N_LEDS-1:0] pattern(input state_t st,
                                                  input logic [STEP_W-1:0] k,
                                                  input logic [1:0] m);
        logic [N_LEDS-1:0] ones;
        logic [N_LEDS-1:0] img;
        ones = '1;
        img  = '0;
        case (st)
            S_INTRO, S_SHOW: begin
                case (m)
                    2'd0:    img = ONE << k;
                    2'd1:    img = ONE << (LAST_LED - k);
                    2'd2:    img = ~((ones << k) << 1);
                    default: img = (k < STEP_W'(N_LEDS)) ? (ONE << k) : (ONE << (BOUNCE_TOP - k));
                endcase
            end
            S_OUTRO: img = ones >> k;
            default: img = '0;
        endcase
        return img;
    endfunction

    always_ff @(posedge MAX10_CLK1_50 or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            step_q  <= '0;
            mode_q  <= '0;
            rep_q   <= '0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            rep_q   <= rep_d;
            leds_q  <= leds_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        step_d   = step_q;
        mode_d   = mode_q;
        rep_d    = rep_q;
        t_last   = '0;
        s_last   = (mode_q == 2'd3) ? STEP_W'(2 * N_LEDS - 3) : LAST_LED;

        case (state_q)
            S_INTRO: t_last = TICK_W'(SLOW_TICKS - 1);
            S_SHOW:  t_last = TICK_W'(FAST_TICKS - 1);
            S_OUTRO: begin
                t_last = TICK_W'(NORM_TICKS - 1);
                s_last = LAST_LED;
            end
            default: t_last = '0;
        endcase

        tick_end = (tick_q == t_last);
        step_end = (step_q == s_last);

        if (bus.stop) begin
            state_d = S_IDLE;
            tick_d  = '0;
            step_d  = '0;
            rep_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d = S_INTRO;
                        mode_d  = bus.mode;
                        tick_d  = '0;
                        step_d  = '0;
                        rep_d   = '0;
                    end
                end
                S_INTRO, S_SHOW, S_OUTRO: begin
                    if (!tick_end) begin
                        tick_d = tick_q + TICK_W'(1);
                    end else begin
                        tick_d = '0;
                        if (!step_end) begin
                            step_d = step_q + STEP_W'(1);
                        end else begin
                            // End of a pass: every phase change restarts at step 0.
                            step_d = '0;
                            case (state_q)
                                S_INTRO: state_d = S_SHOW;
                                S_SHOW: begin
                                    rep_d = rep_q + 4'd1;
                                    if (rep_d == 4'(REPS))
                                        state_d = S_OUTRO;
                                end
                                default: state_d = S_DONE;
                            endcase
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        leds_d = pattern(state_d, step_d, mode_d);
    end

    assign bus.leds     = leds_q;
    assign bus.state    = state_q;
    assign bus.repCount = rep_q;
    assign bus.busy     = (state_q == S_INTRO) || (state_q == S_SHOW) || (state_q == S_OUTRO);
    assign bus.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_light_show_sequencer.sv
// Directed bench for light_show_sequencer with N_LEDS=4, SLOW=2, FAST=1, NORM=3, REPS=2.
module tb_light_show_sequencer;
    logic clk;
    logic resetN;
    int   passed;
    int   total;

    light_show_sequencer_if #(.N_LEDS(4)) bus ();

    light_show_sequencer #(
        .N_LEDS    (4),
        .SLOW_TICKS(2),
        .FAST_TICKS(1),
        .NORM_TICKS(3),
        .REPS      (2)
    ) dut (
        .MAX10_CLK1_50(clk),
        .resetN       (resetN),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN    = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 2'd0;
        #2;
        total++;
        if (bus.state !== 3'd0 || bus.leds !== 4'b0000) begin
            $display("FAIL reset_state_leds: state=%0d leds=%b, expected state=0 leds=0000", bus.state, bus.leds);
        end else passed++;
        total++;
        if (bus.repCount !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL reset_rep_flags: rep=%0d busy=%b done=%b, expected 0/0/0", bus.repCount, bus.busy, bus.done);
        end else passed++;
        step_clk();
        step_clk();
        resetN = 1'b1;
        step_clk();
        step_clk();
        total++;
        if (bus.state !== 3'd0 || bus.leds !== 4'b0000) begin
            $display("FAIL reset_release_idle: state=%0d leds=%b, expected state=0 leds=0000", bus.state, bus.leds);
        end else passed++;
    endtask

    task automatic test_full_run();
        logic [3:0] intro [8];
        logic [3:0] show  [4];
        logic [3:0] outro [4];
        intro = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
        show  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        outro = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
        bus.mode  = 2'd0;
        bus.start = 1'b1;
        step_clk();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.repCount !== 4'd0) begin
            $display("FAIL full_busy: busy=%b rep=%0d, expected busy=1 rep=0", bus.busy, bus.repCount);
        end else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.state !== 3'd1 || bus.leds !== intro[i]) begin
                $display("FAIL full_intro[%0d]: state=%0d leds=%b, expected state=1 leds=%b", i, bus.state, bus.leds, intro[i]);
            end else passed++;
            step_clk();
        end
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (bus.state !== 3'd2 || bus.leds !== show[i] || bus.repCount !== 4'(p)) begin
                    $display("FAIL full_show[%0d][%0d]: state=%0d leds=%b rep=%0d, expected state=2 leds=%b rep=%0d",
                             p, i, bus.state, bus.leds, bus.repCount, show[i], p);
                end else passed++;
                step_clk();
            end
        end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (bus.state !== 3'd3 || bus.leds !== outro[i/3] || bus.repCount !== 4'd2) begin
                $display("FAIL full_outro[%0d]: state=%0d leds=%b rep=%0d, expected state=3 leds=%b rep=2",
                         i, bus.state, bus.leds, bus.repCount, outro[i/3]);
            end else passed++;
            step_clk();
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (bus.state !== 3'd4 || bus.done !== 1'b1 || bus.busy !== 1'b0 ||
                bus.leds !== 4'b0000 || bus.repCount !== 4'd2) begin
                $display("FAIL full_done[%0d]: state=%0d done=%b busy=%b leds=%b rep=%0d, expected 4/1/0/0000/2",
                         i, bus.state, bus.done, bus.busy, bus.leds, bus.repCount);
            end else passed++;
            step_clk();
        end
    endtask

    task automatic test_restart_fill();
        logic [3:0] intro [8];
        intro = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
        bus.mode  = 2'd2;
        bus.start = 1'b1;
        step_clk();
        bus.start = 1'b0;
        total++;
        if (bus.repCount !== 4'd0 || bus.done !== 1'b0) begin
            $display("FAIL fill_restart: rep=%0d done=%b, expected rep=0 done=0", bus.repCount, bus.done);
        end else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.state !== 3'd1 || bus.leds !== intro[i]) begin
                $display("FAIL fill_intro[%0d]: state=%0d leds=%b, expected state=1 leds=%b", i, bus.state, bus.leds, intro[i]);
            end else passed++;
            step_clk();
        end
        bus.stop = 1'b1;
        step_clk();
        bus.stop = 1'b0;
        total++;
        if (bus.state !== 3'd0 || bus.leds !== 4'b0000) begin
            $display("FAIL fill_stop: state=%0d leds=%b, expected state=0 leds=0000", bus.state, bus.leds);
        end else passed++;
    endtask

    task automatic test_stop_mid_show();
        bus.mode  = 2'd0;
        bus.start = 1'b1;
        step_clk();
        bus.start = 1'b0;
        repeat (13) step_clk();
        total++;
        if (bus.state !== 3'd2 || bus.leds !== 4'b0010 || bus.repCount !== 4'd1) begin
            $display("FAIL stop_pre: state=%0d leds=%b rep=%0d, expected state=2 leds=0010 rep=1", bus.state, bus.leds, bus.repCount);
        end else passed++;
        bus.stop = 1'b1;
        step_clk();
        bus.stop = 1'b0;
        total++;
        if (bus.state !== 3'd0 || bus.leds !== 4'b0000 || bus.repCount !== 4'd0) begin
            $display("FAIL stop_abort: state=%0d leds=%b rep=%0d, expected state=0 leds=0000 rep=0", bus.state, bus.leds, bus.repCount);
        end else passed++;
        bus.start = 1'b1;
        step_clk();
        bus.start = 1'b0;
        total++;
        if (bus.state !== 3'd1 || bus.leds !== 4'b0001 || bus.repCount !== 4'd0) begin
            $display("FAIL stop_restart: state=%0d leds=%b rep=%0d, expected state=1 leds=0001 rep=0", bus.state, bus.leds, bus.repCount);
        end else passed++;
        bus.stop = 1'b1;
        step_clk();
        bus.stop = 1'b0;
    endtask

    task automatic test_start_stop_together();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step_clk();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        total++;
        if (bus.state !== 3'd0 || bus.leds !== 4'b0000 || bus.busy !== 1'b0) begin
            $display("FAIL start_stop_same_edge: state=%0d leds=%b busy=%b, expected state=0 leds=0000 busy=0", bus.state, bus.leds, bus.busy);
        end else passed++;
        step_clk();
        total++;
        if (bus.state !== 3'd0) begin
            $display("FAIL start_stop_hold: state=%0d, expected 0", bus.state);
        end else passed++;
    endtask

    task automatic test_bounce_and_reset();
        logic [3:0] pass [6];
        pass = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
        bus.mode  = 2'd3;
        bus.start = 1'b1;
        step_clk();
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (bus.state !== 3'd1 || bus.leds !== pass[i/2]) begin
                $display("FAIL bounce_intro[%0d]: state=%0d leds=%b, expected state=1 leds=%b", i, bus.state, bus.leds, pass[i/2]);
            end else passed++;
            step_clk();
        end
        for (int p = 0; p < 2; p++) begin
            // Second pass runs with start asserted and a different mode requested.
            if (p == 1) begin
                bus.start = 1'b1;
                bus.mode  = 2'd1;
            end
            for (int i = 0; i < 6; i++) begin
                total++;
                if (bus.state !== 3'd2 || bus.leds !== pass[i] || bus.repCount !== 4'(p)) begin
                    $display("FAIL bounce_show[%0d][%0d]: state=%0d leds=%b rep=%0d, expected state=2 leds=%b rep=%0d",
                             p, i, bus.state, bus.leds, bus.repCount, pass[i], p);
                end else passed++;
                step_clk();
            end
        end
        bus.start = 1'b0;
        total++;
        if (bus.state !== 3'd3 || bus.leds !== 4'b1111 || bus.repCount !== 4'd2) begin
            $display("FAIL bounce_outro: state=%0d leds=%b rep=%0d, expected state=3 leds=1111 rep=2", bus.state, bus.leds, bus.repCount);
        end else passed++;
        repeat (4) step_clk();
        total++;
        if (bus.state !== 3'd3 || bus.leds !== 4'b0111) begin
            $display("FAIL outro_pre_reset: state=%0d leds=%b, expected state=3 leds=0111", bus.state, bus.leds);
        end else passed++;
        #2;
        resetN = 1'b0;
        #1;
        total++;
        if (bus.state !== 3'd0 || bus.leds !== 4'b0000 || bus.repCount !== 4'd0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL async_reset: state=%0d leds=%b rep=%0d busy=%b done=%b, expected 0/0000/0/0/0",
                     bus.state, bus.leds, bus.repCount, bus.busy, bus.done);
        end else passed++;
        #3;
        resetN = 1'b1;
        repeat (3) step_clk();
        total++;
        if (bus.state !== 3'd0 || bus.leds !== 4'b0000 || bus.repCount !== 4'd0) begin
            $display("FAIL post_reset_idle: state=%0d leds=%b rep=%0d, expected state=0 leds=0000 rep=0", bus.state, bus.leds, bus.repCount);
        end else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_full_run();
        test_restart_fill();
        test_stop_mid_show();
        test_start_stop_together();
        test_bounce_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/light_show_sequencer.md
LIGHT_SHOW_SEQUENCER -- requirements
Module: light_show_sequencer

Interface
REQ-001 Parameter N_LEDS, default 10, LED count; the legal range is 2..32.
REQ-002 Parameter SLOW_TICKS, default 100000000, clock cycles per step in INTRO; the value SHALL be at least 1.
REQ-003 Parameter FAST_TICKS, default 5000000, clock cycles per step in SHOW; the value SHALL be at least 1.
REQ-004 Parameter NORM_TICKS, default 50000000, clock cycles per step in OUTRO; the value SHALL be at least 1.
REQ-005 Parameter REPS, default 9, number of SHOW passes; the legal range is 1..15.
REQ-006 MAX10_CLK1_50  in  1  sole clock; all logic SHALL be rising-edge triggered.
REQ-007 resetN  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  synchronous request to begin a show, sampled every edge.
REQ-009 stop  in  1  synchronous abort, sampled every edge.
REQ-010 mode  in  2  pattern select, latched on an accepted start: 0 chase-left, 1 chase-right, 2 fill, 3 bounce.
REQ-011 leds  out  N_LEDS  LED drive, registered.
REQ-012 state  out  3  current state: IDLE=0, INTRO=1, SHOW=2, OUTRO=3, DONE=4.
REQ-013 repCount  out  4  number of completed SHOW passes, registered.
REQ-014 busy  out  1  high in INTRO, SHOW or OUTRO.
REQ-015 done  out  1  high in DONE only.

Function
REQ-016 Patterns at step k, where bit 0 is the LSB:
- chase-left: only bit k is on.
- chase-right: only bit N_LEDS-1-k is on.
- fill: bits 0..k are on.
- bounce: bit k is on for k<N_LEDS, otherwise bit 2*N_LEDS-2-k is on.
REQ-017 Pass length P SHALL be N_LEDS for modes 0-2 and 2*N_LEDS-2 for mode 3.
REQ-018 start SHALL be accepted only in IDLE or DONE. On the accepting edge the block SHALL:
- latch mode;
- clear repCount;
- clear the tick counter and step counter;
- enter INTRO with leds = pattern step 0.
REQ-019 Each step SHALL be displayed for exactly T cycles, with T set by the current phase. The step SHALL advance on the edge where the tick counter equals T-1; the tick counter then SHALL wrap to 0.
REQ-020 INTRO SHALL run one pass of the latched pattern at SLOW_TICKS, total P*SLOW_TICKS cycles, then enter SHOW showing step 0.
REQ-021 SHOW SHALL run passes at FAST_TICKS. On the edge that ends each pass, repCount SHALL increment.
REQ-022 When repCount reaches REPS, SHOW SHALL enter OUTRO on that same edge; otherwise SHOW SHALL restart at step 0.
REQ-023 OUTRO SHALL run N_LEDS steps at NORM_TICKS, mode-independent; at step k bits 0..N_LEDS-1-k are on. It then SHALL enter DONE.
REQ-024 DONE SHALL hold leds=0 and keep repCount=REPS until start or stop.
REQ-025 Tick and step counters SHALL clear on every state change.
REQ-026 stop in any state SHALL, at the next edge, force IDLE, leds=0, and repCount=0.
REQ-027 If start and stop are high on the same edge, stop SHALL take precedence.
REQ-028 start while busy SHALL be ignored, and mode changes while busy SHALL have no effect.
REQ-029 repCount SHALL never exceed REPS; it SHALL never wrap.
REQ-030 The tick counter width SHALL be sized from the largest tick parameter; the step counter width SHALL be sized for 2*N_LEDS-2.

Reset
REQ-031 resetN low SHALL immediately force:
- state=IDLE, leds=0, repCount=0, busy=0, done=0;
- tick and step counters and the latched mode to 0.
REQ-032 Reset release SHALL take effect on the first rising edge with resetN high.
REQ-033 Assertion of resetN mid-show SHALL abandon the show without completing the current step.

Verification (N_LEDS=4, SLOW_TICKS=2, FAST_TICKS=1, NORM_TICKS=3, REPS=2)
REQ-034 Full run, mode=0, start pulsed 1 cycle -> expected sequence:
- INTRO: leds 0001,0001,0010,0010,0100,0100,1000,1000;
- SHOW: 0001,0010,0100,1000, repCount=1, then the same four steps, repCount=2;
- OUTRO: 1111 x3, 0111 x3, 0011 x3, 0001 x3;
- then state=4, done=1, leds=0000.
REQ-035 Bounce, mode=3 -> each SHOW pass is 0001,0010,0100,1000,0100,0010 (6 cycles), and INTRO lasts 12 cycles.
REQ-036 stop asserted during the 2nd SHOW pass -> next edge state=0, leds=0000, repCount=0; a later start restarts at INTRO step 0.
REQ-037 start and stop high together in IDLE -> state stays 0; start while in SHOW -> no change to sequence or repCount.
REQ-038 resetN low mid-OUTRO (asynchronous, between edges) -> outputs clear immediately; after release, state=0 until start.
REQ-039 Restart from DONE with mode=2 -> repCount=0, INTRO shows 0001,0011,0111,1111, two cycles each.
